// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller: a Moore FSM that steps each instruction through
// fetch/decode/execute/memory/write-back, drives the datapath enables and counts retired instructions.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   PCWriteCondEQ,
  output logic                   PCWriteCondNE,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic [2:0]             ALUOp,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_MOV   = 6'h06;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, TRAP
  } state_t;

  state_t stateReg, stateNext, targetState;

  logic                   pcWriteReg, condEqReg, condNeReg, iorDReg, memReadReg, memWriteReg;
  logic                   memtoRegReg, regDstReg, regWriteReg, aluSrcAReg;
  logic [1:0]             aluSrcBReg, pcSourceReg;
  logic [2:0]             aluOpReg;
  logic                   doneReg, illegalReg, fetchReg, memWrReg;
  logic [COUNT_WIDTH-1:0] instrCountReg;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      FETCH:    stateNext = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (OP)
          OP_RTYPE:               stateNext = EXEC_R;
          OP_ADDI, OP_ORI, OP_MOV: stateNext = EXEC_I;
          OP_LW, OP_SW:           stateNext = MEM_ADDR;
          OP_BEQ, OP_BNE:         stateNext = BRANCH;
          OP_J:                   stateNext = JUMP;
          default:                stateNext = TRAP;
        endcase
      end
      MEM_ADDR: stateNext = (OP == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   stateNext = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   stateNext = mem_ready ? FETCH : MEM_WR;
      EXEC_R:   stateNext = WB_R;
      EXEC_I:   stateNext = WB_I;
      TRAP:     stateNext = TRAP;
      default:  stateNext = FETCH;
    endcase
  end

  assign targetState = reset ? FETCH : stateNext;

  // Output registers are decoded from the state being entered; OP is stable from DECODE on,
  // so the EXEC_I/BRANCH flavours can be resolved one cycle early.
  always_ff @(posedge clk) begin
    stateReg    <= targetState;
    pcWriteReg  <= 1'b0;
    condEqReg   <= 1'b0;
    condNeReg   <= 1'b0;
    iorDReg     <= 1'b0;
    memReadReg  <= 1'b0;
    memWriteReg <= 1'b0;
    memtoRegReg <= 1'b0;
    regDstReg   <= 1'b0;
    regWriteReg <= 1'b0;
    aluSrcAReg  <= 1'b0;
    aluSrcBReg  <= 2'b00;
    pcSourceReg <= 2'b00;
    aluOpReg    <= 3'b000;
    doneReg     <= 1'b0;
    illegalReg  <= 1'b0;
    fetchReg    <= 1'b0;
    memWrReg    <= 1'b0;
    case (targetState)
      FETCH: begin
        fetchReg   <= 1'b1;
        memReadReg <= 1'b1;
        aluSrcBReg <= 2'b01;
        aluOpReg   <= 3'b100;
      end
      DECODE: begin
        aluSrcBReg <= 2'b11;
        aluOpReg   <= 3'b100;
      end
      MEM_ADDR: begin
        aluSrcAReg <= 1'b1;
        aluSrcBReg <= 2'b10;
        aluOpReg   <= 3'b100;
      end
      MEM_RD: begin
        memReadReg <= 1'b1;
        iorDReg    <= 1'b1;
      end
      MEM_WB: begin
        regWriteReg <= 1'b1;
        memtoRegReg <= 1'b1;
        doneReg     <= 1'b1;
      end
      MEM_WR: begin
        memWrReg    <= 1'b1;
        memWriteReg <= 1'b1;
        iorDReg     <= 1'b1;
      end
      EXEC_R: begin
        aluSrcAReg <= 1'b1;
        aluOpReg   <= 3'b111;
      end
      WB_R: begin
        regWriteReg <= 1'b1;
        regDstReg   <= 1'b1;
        doneReg     <= 1'b1;
      end
      EXEC_I: begin
        aluSrcAReg <= 1'b1;
        aluSrcBReg <= 2'b10;
        aluOpReg   <= (OP == OP_ORI) ? 3'b101 : ((OP == OP_MOV) ? 3'b110 : 3'b100);
      end
      WB_I: begin
        regWriteReg <= 1'b1;
        doneReg     <= 1'b1;
      end
      BRANCH: begin
        aluSrcAReg  <= 1'b1;
        aluOpReg    <= 3'b001;
        pcSourceReg <= 2'b01;
        condEqReg   <= (OP == OP_BEQ);
        condNeReg   <= (OP == OP_BNE);
        doneReg     <= 1'b1;
      end
      JUMP: begin
        pcWriteReg  <= 1'b1;
        pcSourceReg <= 2'b10;
        doneReg     <= 1'b1;
      end
      TRAP:    illegalReg <= 1'b1;
      default: ;
    endcase

    if (reset)
      instrCountReg <= '0;
    else if (instr_done)
      instrCountReg <= instrCountReg + COUNT_WIDTH'(1);
  end

  // Handshake-dependent strobes and the reset blanking are applied combinationally.
  assign PCWrite       = ~reset & (pcWriteReg | (fetchReg & mem_ready));
  assign IRWrite       = ~reset & fetchReg & mem_ready;
  assign instr_done    = ~reset & (doneReg | (memWrReg & mem_ready));
  assign PCWriteCondEQ = ~reset & condEqReg;
  assign PCWriteCondNE = ~reset & condNeReg;
  assign MemRead       = ~reset & memReadReg;
  assign MemWrite      = ~reset & memWriteReg;
  assign RegWrite      = ~reset & regWriteReg;
  assign illegal_op    = ~reset & illegalReg;
  assign IorD          = iorDReg;
  assign MemtoReg      = memtoRegReg;
  assign RegDst        = regDstReg;
  assign ALUSrcA       = aluSrcAReg;
  assign ALUSrcB       = aluSrcBReg;
  assign PCSource      = pcSourceReg;
  assign ALUOp         = aluOpReg;
  assign instr_count   = instrCountReg;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the MIPS datapath. Replaces the per-opcode combinational decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back cycles, and drives the shared memory port, IR, PC and register-file enables. It stalls on a memory-ready handshake, halts on illegal opcodes and counts retired instructions.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset synchronous and active-high
- OP  in  6  opcode from IR[31:26], stable from DECODE onward
- mem_ready  in  1  memory completes access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCondEQ  out  1  PC load if ALU zero
- PCWriteCondNE  out  1  PC load if ALU not zero
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  write-back data: 0=ALUOut, 1=MDR
- RegDst  out  1  dest reg: 0=rt, 1=rd
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUOp  out  3  100=add, 101=or, 001=subtract, 110=pass B, 111=funct decode
- instr_done  out  1  one-cycle pulse on last cycle of each instruction
- illegal_op  out  1  high while halted on illegal opcode
- instr_count  out  COUNT_WIDTH  retired instructions

## Operation
- Opcodes: R-type 0x00, ADDI 0x08, ORI 0x0D, MOV 0x06, BEQ 0x04, BNE 0x05, LW 0x23, SW 0x2B, J 0x02; all others illegal.
- Outputs are a pure function of state (plus OP in EXEC_I/BRANCH, mem_ready in FETCH); every output not listed for a state is 0.
- States and outputs/transitions:
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00; IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; else DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100. Next by OP: R-type->EXEC_R; ADDI/ORI/MOV->EXEC_I; LW/SW->MEM_ADDR; BEQ/BNE->BRANCH; J->JUMP; other->TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100. LW->MEM_RD, SW->MEM_WR.
- MEM_RD: MemRead=1, IorD=1; stay until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; stay until mem_ready; instr_done=mem_ready -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111 -> WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=100 (ADDI)/101 (ORI)/110 (MOV) -> WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWriteCondEQ=1 for BEQ, PCWriteCondNE=1 for BNE; instr_done=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
- TRAP: illegal_op=1, all enables 0; stays until reset.
- instr_count increments by 1 on every cycle with instr_done=1; wraps modulo 2^COUNT_WIDTH, no saturation.

## Timing
- reset sampled high at clock edge: state<=FETCH, instr_count<=0; while reset high all write/read enables (PCWrite, PCWriteCond*, MemRead, MemWrite, IRWrite, RegWrite) and instr_done, illegal_op forced 0.
- Reset mid-instruction or in TRAP aborts immediately; no partial write-back after reset edge.
- Latency with mem_ready=1: R/I-type 4 cycles, LW 5, SW 4, BEQ/BNE 3, J 3. Each cycle of mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle.
- mem_ready ignored outside FETCH/MEM_RD/MEM_WR.
- instr_done and instr_count update coincide: count reflects new value the cycle after the pulse.

## Test plan
- Reset then R-type (OP=0x00), mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R; RegWrite=1,RegDst=1 in cycle 4; instr_count=1.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles total; IRWrite/PCWrite pulse once; MemtoReg=1,RegWrite=1 in final cycle.
- BEQ then BNE -> 3 cycles each; PCWriteCondEQ only for BEQ, PCWriteCondNE only for BNE, ALUOp=001, PCSource=01.
- ADDI/ORI/MOV -> EXEC_I ALUOp 100/101/110 respectively, ALUSrcB=10, RegDst=0.
- OP=0x3F -> TRAP, illegal_op=1 held 20 cycles, instr_count unchanged; reset -> FETCH, illegal_op=0.
- COUNT_WIDTH=4, 17 J instructions -> instr_count wraps 15->0, reads 1; reset asserted in EXEC_R -> next cycle FETCH, no RegWrite.
